// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector execution slice.
// Holds the vector register geometry, the opcode map of the vector unit
// and the state encoding used by the multi-cycle multiply sequencer.
package vec_pkg;

  localparam int ELEM_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;

  localparam logic [3:0] VADD = 4'b0000;
  localparam logic [3:0] VDOT = 4'b0001;
  localparam logic [3:0] SMUL = 4'b0010;
  localparam logic [3:0] SST  = 4'b0011;
  localparam logic [3:0] VLD  = 4'b0100;
  localparam logic [3:0] VST  = 4'b0101;
  localparam logic [3:0] SLL  = 4'b0110;
  localparam logic [3:0] SLH  = 4'b0111;
  localparam logic [3:0] NOP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mul_lane.sv
// mul_lane: one combinational multiply(-accumulate) lane.
// Ports:
//   a, b    - 16-bit element operands
//   addend  - value added to the product (dot-product running sum)
//   mode    - 1 = scale (SMUL): addend ignored; 0 = multiply-accumulate
//   y       - (a*b + addend) truncated to 16 bits, two's complement wrap
module mul_lane
  import vec_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [ELEM_W-1:0] addend,
  input  logic              mode,
  output logic [ELEM_W-1:0] y
);

  logic [ELEM_W-1:0] prod;
  logic [ELEM_W-1:0] addend_eff;

  // Low 16 bits of the product are identical for signed and unsigned
  // operands, so a plain truncating multiply gives the wrapped result.
  assign prod       = a * b;
  assign addend_eff = mode ? '0 : addend;
  assign y          = prod + addend_eff;

endmodule

// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: multi-cycle VDOT / SMUL engine beside the vector ALU.
// Accepts one operation through start/busy/done, latches both operands and
// walks the elements LANES at a time on shared mul_lane instances.
// Ports:
//   clk, rst        - clock (rising edge), async active-high reset
//   start, opcode   - operation request; only VDOT and SMUL are accepted
//   op_1, op_2      - operand A; operand B (VDOT) or scalar in [15:0] (SMUL)
//   busy            - operation in progress, starts ignored
//   done            - one-cycle pulse, result valid from this cycle
//   result          - completed result in ALU result-bus format
//   illegal         - one-cycle pulse after a refused (bad opcode) start
module vec_mul_sequencer
  import vec_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [VEC_W-1:0] op_1,
  input  logic [VEC_W-1:0] op_2,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] result,
  output logic             illegal
);

  localparam int IDX_W = $clog2(NUM_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

  seq_state_t state, state_next;

  logic [VEC_W-1:0]  a_q;
  logic [VEC_W-1:0]  b_q;
  logic [3:0]        op_q;
  logic [IDX_W-1:0]  idx;
  logic [ELEM_W-1:0] acc;
  logic [ELEM_W-1:0] acc_next;
  logic [VEC_W-1:0]  shadow;
  logic [VEC_W-1:0]  shadow_next;

  logic legal_op;
  logic can_start;
  logic accept;
  logic refuse;
  logic last_group;
  logic is_smul;

  logic [IDX_W-1:0]  lane_idx [LANES];
  logic [ELEM_W-1:0] lane_a   [LANES];
  logic [ELEM_W-1:0] lane_b   [LANES];
  logic [ELEM_W-1:0] lane_add [LANES];
  logic [ELEM_W-1:0] lane_out [LANES];

  // Starts are only looked at outside RUN; the DONE cycle can accept a
  // new operation so back-to-back issue loses no cycle.
  assign legal_op   = (opcode == VDOT) || (opcode == SMUL);
  assign can_start  = (state != RUN);
  assign accept     = start && can_start && legal_op;
  assign refuse     = start && can_start && !legal_op;
  assign last_group = (state == RUN) && (idx == LAST_IDX);
  assign is_smul    = (op_q == SMUL);

  // Lanes are chained: lane 0 adds the running accumulator and each later
  // lane adds its predecessor, so the last lane yields the new dot sum.
  // In SMUL mode the chain is ignored and every lane writes one element.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = idx + IDX_W'(l);
    assign lane_a[l]   = a_q[lane_idx[l]*ELEM_W +: ELEM_W];
    assign lane_b[l]   = is_smul ? b_q[ELEM_W-1:0]
                                 : b_q[lane_idx[l]*ELEM_W +: ELEM_W];
    if (l == 0) begin : g_first
      assign lane_add[l] = acc;
    end else begin : g_chain
      assign lane_add[l] = lane_out[l-1];
    end
    mul_lane u_lane (
      .a      (lane_a[l]),
      .b      (lane_b[l]),
      .addend (lane_add[l]),
      .mode   (is_smul),
      .y      (lane_out[l])
    );
  end

  assign acc_next = lane_out[LANES-1];

  // Shadow vector with the current group's products merged in; on the
  // final edge this is the complete SMUL result.
  always_comb begin
    shadow_next = shadow;
    for (int l = 0; l < LANES; l++) begin
      shadow_next[lane_idx[l]*ELEM_W +: ELEM_W] = lane_out[l];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_group) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand latches, index, accumulator, shadow and result.
  // The result register only moves on the completion edge, so it holds
  // the previous answer through refused starts and later operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx     <= '0;
      acc     <= '0;
      shadow  <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= refuse;
      if (accept) begin
        a_q  <= op_1;
        b_q  <= op_2;
        op_q <= opcode;
        idx  <= '0;
        acc  <= '0;
      end else if (state == RUN) begin
        idx    <= idx + IDX_STEP;
        acc    <= acc_next;
        shadow <= shadow_next;
        if (last_group) begin
          result <= is_smul ? shadow_next
                            : {{(VEC_W-ELEM_W){1'b0}}, acc_next};
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// tb_vec_mul_sequencer: scoreboard bench for vec_mul_sequencer.
// Stimulus pushes the expected result and accept cycle into a queue; an
// independent monitor pops and compares on every done pulse.
module tb_vec_mul_sequencer;
  import vec_pkg::*;

  localparam int LAT = NUM_ELEM;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       opcode;
  logic [VEC_W-1:0] op_1;
  logic [VEC_W-1:0] op_2;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] result;
  logic             illegal;

  typedef struct {
    logic [VEC_W-1:0] res;
    int               accept_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  vec_mul_sequencer #(.LANES(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .opcode  (opcode),
    .op_1    (op_1),
    .op_2    (op_2),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  // 10 ns clock and a free-running edge counter for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [VEC_W-1:0] actual,
                             input logic [VEC_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one request (called just after a falling edge), records the
  // expected answer and the edge that will accept it, then scrambles the
  // inputs so any late sampling of them would corrupt the result.
  task automatic applyStimulus(input logic [3:0] op, input logic [VEC_W-1:0] a,
                               input logic [VEC_W-1:0] b, input logic [VEC_W-1:0] exp_res);
    exp_t e;
    start  = 1'b1;
    opcode = op;
    op_1   = a;
    op_2   = b;
    e.res        = exp_res;
    e.accept_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = NOP;
    op_1   = {8{$urandom()}};
    op_2   = {8{$urandom()}};
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 3 * LAT && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles", 3 * LAT);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request,
  // both in value and in latency from its accepting edge.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("latency", VEC_W'(cyc - e.accept_cyc), VEC_W'(LAT));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb;
    bit seen;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = NOP;
    op_1   = '0;
    op_2   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", VEC_W'(busy), '0);
    checkOutput("reset_done", VEC_W'(done), '0);
    checkOutput("reset_illegal", VEC_W'(illegal), '0);
    checkOutput("reset_result", result, '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] VDOT ones x twos");
    applyStimulus(VDOT, {16{16'h0001}}, {16{16'h0002}}, VEC_W'(16'h0020));
    wait_done(nb);
    checkOutput("vdot_busy_cycles", VEC_W'(nb), VEC_W'(LAT));
    @(negedge clk);
    checkOutput("vdot_done_width", VEC_W'(done), '0);
    checkOutput("vdot_busy_after", VEC_W'(busy), '0);

    $display("[TB] SMUL index x 3");
    applyStimulus(SMUL,
      {16'h000F, 16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A, 16'h0009, 16'h0008,
       16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000},
      VEC_W'(16'h0003),
      {16'h002D, 16'h002A, 16'h0027, 16'h0024, 16'h0021, 16'h001E, 16'h001B, 16'h0018,
       16'h0015, 16'h0012, 16'h000F, 16'h000C, 16'h0009, 16'h0006, 16'h0003, 16'h0000});
    wait_done(nb);
    @(negedge clk);
    checkOutput("smul_done_width", VEC_W'(done), '0);

    $display("[TB] VDOT wrap and sign");
    applyStimulus(VDOT, {16{16'h0100}}, {16{16'h0100}}, '0);
    wait_done(nb);
    @(negedge clk);
    applyStimulus(VDOT, VEC_W'(16'hFFFF), VEC_W'(16'h0001), VEC_W'(16'hFFFF));
    wait_done(nb);
    @(negedge clk);

    $display("[TB] illegal opcode in IDLE");
    start  = 1'b1;
    opcode = VADD;
    op_1   = {16{16'h1111}};
    op_2   = {16{16'h2222}};
    @(negedge clk);
    start = 1'b0;
    checkOutput("illegal_pulse", VEC_W'(illegal), VEC_W'(1));
    checkOutput("illegal_busy", VEC_W'(busy), '0);
    @(negedge clk);
    checkOutput("illegal_width", VEC_W'(illegal), '0);
    checkOutput("illegal_result_held", result, VEC_W'(16'hFFFF));

    $display("[TB] start during RUN ignored");
    applyStimulus(VDOT, {16{16'h0003}}, {16{16'h0005}}, VEC_W'(16'h00F0));
    repeat (4) @(negedge clk);
    start  = 1'b1;
    opcode = SMUL;
    op_1   = {16{16'h7777}};
    op_2   = {16{16'h0009}};
    @(negedge clk);
    start  = 1'b0;
    opcode = NOP;
    checkOutput("run_start_no_illegal", VEC_W'(illegal), '0);
    checkOutput("run_start_busy", VEC_W'(busy), VEC_W'(1));
    wait_done(nb);
    @(negedge clk);

    $display("[TB] back-to-back issue");
    applyStimulus(VDOT, {16{16'h0001}}, {16{16'h0001}}, VEC_W'(16'h0010));
    wait_done(nb);
    applyStimulus(SMUL, {16{16'h0002}}, {{15{16'h1234}}, 16'hFFFF}, {16{16'hFFFE}});
    wait_done(nb);
    checkOutput("b2b_busy_cycles", VEC_W'(nb), VEC_W'(LAT));
    @(negedge clk);

    $display("[TB] reset mid-operation");
    applyStimulus(VDOT, {16{16'h0001}}, {16{16'h0002}}, VEC_W'(16'h0020));
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", VEC_W'(busy), '0);
    checkOutput("abort_done", VEC_W'(done), '0);
    checkOutput("abort_result", result, '0);
    sb.delete();
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("no_done_after_abort", VEC_W'(seen), '0);
    checkOutput("scoreboard_empty", VEC_W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
